// File: rtl/pwm_ramp_gen.sv
// pwm_ramp_gen: ramped-duty PWM driving the RC ramp of the PWM-ramp ADC.
// Define PWM_RAMP_SETTLE_EN to hold pwm_o low for SETTLE_PERIODS periods after each clear.
module pwm_ramp_gen #(
    parameter int NBITS          = 8,
    parameter int PRESCALE_W     = 8,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [NBITS-1:0]      step_i,
    output logic                  pwm_o,
    output logic [NBITS-1:0]      pwm_dc_o,
    output logic                  period_done_o,
    output logic                  ramp_wrap_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] psc;
    logic [NBITS-1:0]      cnt;
    logic [NBITS-1:0]      dc;
    logic                  tick;
    logic                  period_end;
    logic [NBITS:0]        dc_sum;

`ifdef PWM_RAMP_SETTLE_EN
    localparam int SW = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
    logic [SW-1:0] settle_cnt;
`endif

    // The carry bit of dc_sum flags a duty overflow that must wrap to zero.
    assign tick       = (state != ST_IDLE) && (psc == '0);
    assign period_end = tick && (cnt == '1);
    assign dc_sum     = {1'b0, dc} + {1'b0, step_i};
    assign pwm_dc_o   = dc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            psc           <= '0;
            cnt           <= '0;
            dc            <= '0;
            pwm_o         <= 1'b0;
            period_done_o <= 1'b0;
            ramp_wrap_o   <= 1'b0;
            busy_o        <= 1'b0;
`ifdef PWM_RAMP_SETTLE_EN
            settle_cnt    <= '0;
`endif
        end else begin
            period_done_o <= 1'b0;
            ramp_wrap_o   <= 1'b0;
            pwm_o         <= (state == ST_RUN) && (cnt < dc);
            case (state)
                ST_IDLE: begin
                    if (clear_i) begin
                        dc <= '0;
                    end else if (en_i) begin
                        state  <= ST_RUN;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    if (!en_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                        psc    <= '0;
                        if (clear_i) begin
                            dc <= '0;
                        end
                    end else if (clear_i) begin
                        // Clear aborts the current period: no done or wrap pulse for it.
                        cnt <= '0;
                        psc <= '0;
                        dc  <= '0;
`ifdef PWM_RAMP_SETTLE_EN
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
`endif
                    end else begin
                        if (tick) begin
                            psc <= prescale_i;
                            cnt <= cnt + NBITS'(1);
                        end else begin
                            psc <= psc - PRESCALE_W'(1);
                        end
                        period_done_o <= period_end;
                        if (period_end) begin
                            if (state == ST_RUN) begin
                                if (dc_sum[NBITS]) begin
                                    dc          <= '0;
                                    ramp_wrap_o <= 1'b1;
                                end else begin
                                    dc <= dc_sum[NBITS-1:0];
                                end
                            end
`ifdef PWM_RAMP_SETTLE_EN
                            else begin
                                if (settle_cnt == SETTLE_LAST) begin
                                    state      <= ST_RUN;
                                    settle_cnt <= '0;
                                end else begin
                                    settle_cnt <= settle_cnt + SW'(1);
                                end
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
